// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp -- single-port data memory with a request/response handshake and
// a programmable response latency.
//
// Parameters
//   MEM_SIZE     memory depth in 32-bit words (default 1024)
//   WAIT_STATES  extra cycles between request accept and response, 0..15
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   CPU request present
//   req_ready  out  block can accept a request (IDLE only)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address; word index is addr[31:2]
//   req_wdata  in   write data
//   req_be     in   byte enables, bit n covers wdata[8n+7:8n]
//   rsp_valid  out  response present (RESP only)
//   rsp_ready  in   CPU accepts the response
//   rsp_rdata  out  read data (0 for writes and errors)
//   rsp_err    out  request failed, no memory side effect
//
// Configuration
//   DMEM_ALIGN_CHECK_EN  when defined, a request with req_addr[1:0] != 0 is
//                        rejected with rsp_err=1; when undefined the low
//                        address bits are ignored.
//
// The memory array is never initialised or reset; only the handshake state
// and response registers are cleared by rst_n.
// -----------------------------------------------------------------------------
module dmem_resp #(
  parameter int unsigned MEM_SIZE    = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Captured request payload
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  req_t           lat_q, lat_d;
  req_t           req_in;
  req_t           acc;
  logic [31:0]    rdata_d;
  logic           err_d;
  logic           do_access;
  logic           mem_wr;
  logic [IW-1:0]  idx;
  logic           in_range;
  logic           misalign;
  logic           acc_ok;

  logic [31:0]    mem [MEM_SIZE];

  assign req_in = {req_we, req_addr, req_wdata, req_be};

  // Access source: with zero wait states the access happens on the accept
  // edge itself, so the live request is used; otherwise the latched copy.
  always_comb begin
    acc = (state_q == IDLE) ? req_in : lat_q;
  end

  // Address decode of the access
  assign idx      = acc.addr[IW+1:2];
  assign in_range = (acc.addr[31:2] < 30'(MEM_SIZE));

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |acc.addr[1:0];
`else
  logic unused_addr_lsb;
  assign misalign        = 1'b0;
  assign unused_addr_lsb = ^acc.addr[1:0];
`endif

  assign acc_ok = in_range & ~misalign;

  // Next-state, counter, capture and response logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    rdata_d   = rsp_rdata;
    err_d     = rsp_err;
    do_access = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_d = req_in;
          if (WS == 4'd0) begin
            state_d   = RESP;
            do_access = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end

      // Counter loaded with WAIT_STATES on accept; RESP is entered on the
      // edge after it reaches zero, i.e. accept edge + 1 + WAIT_STATES.
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // Hold everything until the CPU takes the response; no accept here.
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (do_access) begin
      err_d   = ~acc_ok;
      rdata_d = (acc_ok && !acc.we) ? mem[idx] : 32'd0;
    end
  end

  // Gated by rst_n so a request seen during reset never reaches the array.
  assign mem_wr = do_access & acc_ok & acc.we & rst_n;

  // State and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lat_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

  // Byte-enabled write port; array contents are not reset
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (acc.be[b]) begin
          mem[idx][8*b +: 8] <= acc.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp -- self-checking bench for dmem_resp (MEM_SIZE=1024,
// WAIT_STATES=2). A word/byte-known reference memory predicts every response.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned WS       = 2;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run;
  int tests_failed;

  // Reference memory: value plus per-byte "has been written" mask
  logic [31:0] mdl   [MEM_SIZE];
  logic [3:0]  known [MEM_SIZE];

  dmem_resp #(.MEM_SIZE(MEM_SIZE), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction with model prediction, latency, backpressure and
  // release checks. Inputs are scrambled while the block is busy.
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int hold, input string name,
                         output logic [31:0] got_rdata, output logic got_err);
    logic [29:0] widx;
    int          wi;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] mask;
    logic [31:0] r0;
    logic        e0;
    int          lat;

    widx      = addr[31:2];
    exp_err   = (widx >= 30'(MEM_SIZE)) || (ALIGN_EN && (addr[1:0] != 2'b00));
    wi        = exp_err ? 0 : int'(widx);
    exp_rdata = 32'd0;
    mask      = 32'hFFFF_FFFF;
    if (!we && !exp_err) begin
      exp_rdata = mdl[wi];
      mask = {{8{known[wi][3]}}, {8{known[wi][2]}}, {8{known[wi][1]}}, {8{known[wi][0]}}};
    end

    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s idle_ready: req_ready=%b expected 1", name, req_ready);
    end

    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);

    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after_accept: req_ready=%b rsp_valid=%b expected 0/0", name, req_ready, rsp_valid);
    end

    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      req_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat != int'(WS) + 1) begin
      tests_failed++;
      $display("FAIL %s latency: edges=%0d expected %0d", name, lat, WS + 1);
    end

    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    tests_run++;
    if (rsp_err !== exp_err || (rsp_rdata & mask) !== (exp_rdata & mask)) begin
      tests_failed++;
      $display("FAIL %s response: rdata=%h err=%b expected rdata=%h err=%b (mask %h)",
               name, rsp_rdata, rsp_err, exp_rdata, exp_err, mask);
    end

    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mdl[wi][8*b +: 8] = wdata[8*b +: 8];
          known[wi][b] = 1'b1;
        end
      end
    end

    r0 = rsp_rdata; e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s hold[%0d]: valid=%b rdata=%h err=%b ready=%b expected 1/%h/%b/0",
                 name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
      end
    end

    // A request offered on the leaving edge must not be taken
    rsp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s release: rsp_valid=%b req_ready=%b expected 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic e;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b expected 1/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First posedge after release must accept (latency check covers it)
    run_txn(1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 0, "first_accept", d, e);
  endtask

  task automatic test_spec_vectors;
    logic [31:0] d; logic e;
    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "wr_deadbeef", d, e);
    tests_run++;
    if (e !== 1'b0 || d !== 32'd0) begin
      tests_failed++;
      $display("FAIL wr_resp: rdata=%h err=%b expected 0/0", d, e);
    end
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1, "rd_deadbeef", d, e);
    tests_run++;
    if (d !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL rd_deadbeef_const: rdata=%h expected deadbeef", d);
    end
    run_txn(1'b1, 32'h10, 32'h1122_3344, 4'h5, 0, "wr_be5", d, e);
    run_txn(1'b0, 32'h10, 32'h0, 4'hA, 0, "rd_be5", d, e);
    tests_run++;
    if (d !== 32'hDE22_BE44) begin
      tests_failed++;
      $display("FAIL rd_be5_const: rdata=%h expected de22be44", d);
    end
    run_txn(1'b1, 32'h10, 32'h5555_5555, 4'h0, 0, "wr_be0", d, e);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd_be0", d, e);
    tests_run++;
    if (d !== 32'hDE22_BE44) begin
      tests_failed++;
      $display("FAIL rd_be0_const: rdata=%h expected de22be44", d);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d; logic e;
    run_txn(1'b1, 32'hFFC, 32'hA5A5_A5A5, 4'hF, 0, "wr_last_word", d, e);
    run_txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, "rd_last_word", d, e);
    run_txn(1'b0, 32'h1000, 32'h0, 4'hF, 0, "rd_oob", d, e);
    tests_run++;
    if (e !== 1'b1 || d !== 32'd0) begin
      tests_failed++;
      $display("FAIL rd_oob_const: rdata=%h err=%b expected 0/1", d, e);
    end
    run_txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, "wr_oob", d, e);
    run_txn(1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 4'hF, 0, "wr_oob_high", d, e);
    run_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, "rd_word0_after_oob", d, e);
    tests_run++;
    if (d !== 32'h0102_0304) begin
      tests_failed++;
      $display("FAIL word0_alias: rdata=%h expected 01020304", d);
    end
    run_txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, "rd_last_after_oob", d, e);
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic e;
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, "backpressure5", d, e);
  endtask

  task automatic test_misaligned;
    logic [31:0] d; logic e;
    run_txn(1'b1, 32'h20, 32'hCAFE_0020, 4'hF, 0, "wr_20", d, e);
    run_txn(1'b0, 32'h22, 32'h0, 4'h0, 0, "rd_22", d, e);
    tests_run++;
    if (e !== ALIGN_EN || (!ALIGN_EN && d !== 32'hCAFE_0020)) begin
      tests_failed++;
      $display("FAIL rd_22_const: rdata=%h err=%b expected err=%b", d, e, ALIGN_EN);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] d; logic e;
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "rd_20_before", d, e);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BAD_F00D; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_wait: ready=%b valid=%b rdata=%h err=%b expected 1/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "rd_20_after_abort", d, e);
    tests_run++;
    if (d !== 32'hCAFE_0020) begin
      tests_failed++;
      $display("FAIL abort_no_write: rdata=%h expected cafe0020", d);
    end
  endtask

  task automatic test_reset_in_resp;
    logic [31:0] d; logic e;
    int n;
    req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'h0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22_BE44) begin
      tests_failed++;
      $display("FAIL resp_before_reset: valid=%b rdata=%h expected 1/de22be44", rsp_valid, rsp_rdata);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_resp: valid=%b rdata=%h err=%b ready=%b expected 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd_after_resp_reset", d, e);
  endtask

  task automatic test_random;
    logic [31:0] d; logic e;
    logic [31:0] a;
    int mode;
    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0)
        a = (32'($urandom_range(1024, 4095)) << 2);
      else if (mode == 1)
        a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (mode == 2)
        a = $urandom | 32'h8000_0000;
      else
        a = (32'($urandom_range(0, 63)) << 2);
      run_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
              $sformatf("rand%0d", i), d, e);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < int'(MEM_SIZE); i++) begin
      mdl[i] = 32'd0;
      known[i] = 4'h0;
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_be = 4'h0; rsp_ready = 1'b0; rst_n = 1'b0;

    test_reset;
    test_spec_vectors;
    test_out_of_range;
    test_backpressure;
    test_misaligned;
    test_reset_in_wait;
    test_reset_in_resp;
    test_random;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
